// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory handshake bundle for mem_port_arbiter
// slave is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data ports
// Each access runs issue -> latency wait -> done; data port wins ties unless it won the last grant.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t        state;
  logic [3:0]    cnt;
  logic          last_d;
  logic          grant_d;
  logic          we_q;
  logic          busy_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          if_ready_q;
  logic          d_ready_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          pick_d;

  // A tie goes to the data port unless it also took the previous grant.
  assign pick_d = bus.d_req & ~(bus.if_req & last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_d      <= 1'b0;
      grant_d     <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req | bus.d_req) begin
            grant_d    <= pick_d;
            last_d     <= pick_d;
            we_q       <= pick_d & bus.d_we;
            mem_we_q   <= pick_d & bus.d_we;
            mem_addr_q <= pick_d ? bus.d_addr : bus.if_addr;
            if (pick_d) begin
              mem_wdata_q <= bus.d_wdata;
            end
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            d_ready_q  <= grant_d;
            if_ready_q <= ~grant_d;
            state      <= DONE;
          end else begin
            cnt   <= 4'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          // cnt == LAT lines up with the cycle the memory presents read data.
          if (cnt == LAT_C) begin
            if (grant_d) begin
              d_rdata_q <= bus.mem_rdata;
            end else begin
              if_rdata_q <= bus.mem_rdata;
            end
            d_ready_q  <= grant_d;
            if_ready_q <= ~grant_d;
            cnt        <= 4'd0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
// Expected timing and data come from a transaction-level model of the grant rules.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] L1_DATA  = 32'h1111_0001;
  localparam logic [31:0] L15_DATA = 32'hFFFF_000F;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus15 ();

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1))   u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(15))  u_lat15 (.clk(clk), .rst(rst), .bus(bus15));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] env_mem [64];
  bit          ref_last_d;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory for the main DUT: read data is only valid in the cycle LAT after mem_en.
  int          rem = 0;
  logic [31:0] pend = '0;
  always @(negedge clk) begin
    if (rem > 0) rem = rem - 1;
    if (bus.mem_en) begin
      if (bus.mem_we) env_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      else begin
        rem  = LAT + 1;
        pend = env_mem[bus.mem_addr[7:2]];
      end
    end
    bus.mem_rdata = (rem == 1) ? pend : $urandom;
  end

  int rem1 = 0;
  int rem15 = 0;
  always @(negedge clk) begin
    if (rem1 > 0) rem1 = rem1 - 1;
    if (rem15 > 0) rem15 = rem15 - 1;
    if (bus1.mem_en) rem1 = 2;
    if (bus15.mem_en) rem15 = 16;
    bus1.mem_rdata  = (rem1 == 1) ? L1_DATA : $urandom;
    bus15.mem_rdata = (rem15 == 1) ? L15_DATA : $urandom;
  end

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration round: requests raised together, each held until its ready.
  task automatic run_round(input bit ri, input bit rd, input bit we,
                           input logic [5:0] ii, input logic [5:0] di, input logic [31:0] wd);
    bit          both, win_d, w1, w2;
    int          lat_d, r1, g2, r2, t_if, t_d, last;
    logic [31:0] a_i, a_d, a1, a2;
    both  = ri && rd;
    win_d = both ? !ref_last_d : rd;
    lat_d = we ? 2 : LAT + 2;
    r1    = win_d ? lat_d : LAT + 2;
    g2    = both ? r1 + 1 : -10;
    r2    = both ? g2 + (win_d ? LAT + 2 : lat_d) : -10;
    t_d   = !rd ? -1 : (win_d ? r1 : r2);
    t_if  = !ri ? -1 : (win_d ? r2 : r1);
    a_i   = {24'd0, ii, 2'b00};
    a_d   = {24'd0, di, 2'b00};
    a1    = win_d ? a_d : a_i;
    a2    = win_d ? a_i : a_d;
    w1    = win_d && we;
    w2    = !win_d && we;
    if (win_d) begin
      if (we) ref_mem[di] = wd; else exp_d_rdata = ref_mem[di];
      if (ri) exp_if_rdata = ref_mem[ii];
    end else begin
      if (ri) exp_if_rdata = ref_mem[ii];
      if (rd) begin
        if (we) ref_mem[di] = wd; else exp_d_rdata = ref_mem[di];
      end
    end
    ref_last_d = both ? !win_d : win_d;
    last = both ? r2 : r1;
    bus.if_req  = ri;
    bus.if_addr = a_i;
    bus.d_req   = rd;
    bus.d_we    = we;
    bus.d_addr  = a_d;
    bus.d_wdata = wd;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chkb("if_ready", bus.if_ready, c == t_if);
      chkb("d_ready", bus.d_ready, c == t_d);
      chkb("mem_en", bus.mem_en, c == 1 || c == g2 + 1);
      chkb("busy", bus.busy, (c >= 1 && c <= r1) || (c >= g2 + 1 && c <= r2));
      chkb("stall_if", bus.stall_if, ri && c < t_if);
      chkb("stall_mem", bus.stall_mem, rd && c < t_d);
      if (c == 1) begin
        chkw("mem_addr1", bus.mem_addr, a1);
        chkb("mem_we1", bus.mem_we, w1);
        if (w1) chkw("mem_wdata1", bus.mem_wdata, wd);
      end
      if (c == g2 + 1) begin
        chkw("mem_addr2", bus.mem_addr, a2);
        chkb("mem_we2", bus.mem_we, w2);
        if (w2) chkw("mem_wdata2", bus.mem_wdata, wd);
      end
      if (c == t_if) chkw("if_rdata", bus.if_rdata, exp_if_rdata);
      if (c == t_d) chkw("d_rdata", bus.d_rdata, exp_d_rdata);
      @(posedge clk);
      #1;
      if (c == 0) begin
        if (win_d) begin
          bus.d_addr  = $urandom;
          bus.d_wdata = $urandom;
        end else begin
          bus.if_addr = $urandom;
        end
      end
      if (c == t_if) bus.if_req = 1'b0;
      if (c == t_d) bus.d_req = 1'b0;
    end
    chkw("if_rdata_hold", bus.if_rdata, exp_if_rdata);
    chkw("d_rdata_hold", bus.d_rdata, exp_d_rdata);
  endtask

  initial begin
    bit          w;
    int          t, r;
    logic [1:0]  sel;
    logic [31:0] v;
    rst = 1'b1;
    bus.if_req = 0;   bus.if_addr = 0;   bus.d_req = 0;   bus.d_we = 0;   bus.d_addr = 0;   bus.d_wdata = 0;
    bus1.if_req = 0;  bus1.if_addr = 0;  bus1.d_req = 0;  bus1.d_we = 0;  bus1.d_addr = 0;  bus1.d_wdata = 0;
    bus15.if_req = 0; bus15.if_addr = 0; bus15.d_req = 0; bus15.d_we = 0; bus15.d_addr = 0; bus15.d_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      env_mem[i] = v;
    end
    ref_last_d   = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_mem_en", bus.mem_en, 1'b0);
    chkb("rst_mem_we", bus.mem_we, 1'b0);
    chkb("rst_if_ready", bus.if_ready, 1'b0);
    chkb("rst_d_ready", bus.d_ready, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);
    chkw("rst_mem_addr", bus.mem_addr, 32'd0);
    chkw("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chkw("rst_if_rdata", bus.if_rdata, 32'd0);
    chkw("rst_d_rdata", bus.d_rdata, 32'd0);
    chkb("rst_busy_l15", bus15.busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a data read sits in WAIT.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chkb("mid_wait_busy", bus.busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chkb("rstw_busy", bus.busy, 1'b0);
    chkb("rstw_mem_en", bus.mem_en, 1'b0);
    chkb("rstw_mem_we", bus.mem_we, 1'b0);
    chkb("rstw_d_ready", bus.d_ready, 1'b0);
    chkw("rstw_d_rdata", bus.d_rdata, 32'd0);
    bus.d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chkb("post_rst_d_ready", bus.d_ready, 1'b0);
      chkb("post_rst_if_ready", bus.if_ready, 1'b0);
      chkb("post_rst_busy", bus.busy, 1'b0);
      @(posedge clk);
      #1;
    end
    ref_last_d   = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    run_round(1'b1, 1'b0, 1'b0, 6'd1, 6'd0, 32'd0);

    // Single fetch from 0x10.
    ref_mem[4] = 32'h8C22_0004;
    env_mem[4] = 32'h8C22_0004;
    run_round(1'b1, 1'b0, 1'b0, 6'd4, 6'd0, 32'd0);

    // Store to 0x20.
    run_round(1'b0, 1'b1, 1'b1, 6'd0, 6'd8, 32'hDEAD_BEEF);

    // Tie straight after reset: data load to 0x40 goes first.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_last_d   = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    run_round(1'b1, 1'b1, 1'b0, 6'd2, 6'd16, 32'd0);

    // Both ports held across four completions: grants must alternate.
    w = !ref_last_d;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0C;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h14;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      r = t + LAT + 2;
      if (w) exp_d_rdata = ref_mem[5]; else exp_if_rdata = ref_mem[3];
      for (int c = t; c <= r; c++) begin
        @(negedge clk);
        chkb("fair_if_ready", bus.if_ready, c == r && !w);
        chkb("fair_d_ready", bus.d_ready, c == r && w);
        chkb("fair_mem_en", bus.mem_en, c == t + 1);
        if (c == r) begin
          if (w) chkw("fair_d_rdata", bus.d_rdata, exp_d_rdata);
          else   chkw("fair_if_rdata", bus.if_rdata, exp_if_rdata);
        end
        @(posedge clk);
        #1;
      end
      ref_last_d = w;
      w = !w;
      t = r + 1;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    for (int k = 0; k < 24; k++) begin
      sel = 2'($urandom_range(1, 3));
      run_round(sel[0], sel[1], 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // LAT=1 and LAT=15 builds, one fetch each.
    bus1.if_req   = 1'b1;
    bus1.if_addr  = 32'h8;
    bus15.if_req  = 1'b1;
    bus15.if_addr = 32'h8;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      chkb("l1_ready", bus1.if_ready, c == 3);
      chkb("l15_ready", bus15.if_ready, c == 17);
      chkb("l1_mem_en", bus1.mem_en, c == 1);
      chkb("l15_mem_en", bus15.mem_en, c == 1);
      chkb("l1_busy", bus1.busy, c >= 1 && c <= 3);
      chkb("l15_busy", bus15.busy, c >= 1 && c <= 17);
      if (c == 3) chkw("l1_rdata", bus1.if_rdata, L1_DATA);
      if (c == 17) chkw("l15_rdata", bus15.if_rdata, L15_DATA);
      @(posedge clk);
      #1;
      if (c == 3) bus1.if_req = 1'b0;
      if (c == 17) bus15.if_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage lw/sw).
- Sequences each access as issue → latency wait → completion and returns per-port ready pulses.
- Produces stall_if / stall_mem, which the pipeline ORs into its PC/IR write-enable and stage-freeze logic alongside load-use and branch stalls.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory read latency in cycles after the cycle mem_en is high (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  instruction fetch request; held until if_ready
- if_addr  in  AW  fetch byte address
- if_rdata  out  DW  fetched instruction; held until the next IF completion
- if_ready  out  1  one-cycle completion pulse for IF
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; held until the next data-read completion
- d_ready  out  1  one-cycle completion pulse for data port
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  d_req & ~d_ready (combinational)
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, cnt=0, last_grant=IF. Outputs mem_en, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0. An access in flight is abandoned with no ready pulse.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except stall_if and stall_mem are registered.
- IDLE, with no request pending: stay in IDLE.
- IDLE, with a request pending: latch grant (IF or D), address, we and wdata, then go to ISSUE.
  - IF reads always use we=0.
  - Tie (if_req & d_req): D wins unless last_grant==D, in which case IF wins. This prevents fetch starvation. Update last_grant at grant time.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata driven.
  - Write: next state is DONE.
  - Read: next state is WAIT with cnt=1.
- WAIT: cnt increments each cycle. In the cycle where cnt==LAT, capture mem_rdata into if_rdata or d_rdata according to the grant, then go to DONE.
- DONE (1 cycle): the granted port's ready=1. Requests are ignored in this cycle because the requester still holds req. Next state is IDLE.
- Latency, from req first seen in IDLE at cycle 0:
  - mem_en high in cycle 1.
  - Read: ready in cycle LAT+2.
  - Write: ready in cycle 2.
  - Earliest next grant is cycle LAT+3 (read) or cycle 3 (write).
- Request changes: req dropping before ready is illegal (no required behaviour). Address or data changes after the grant are ignored.
- Ready exclusivity: if_ready and d_ready are never high in the same cycle. A ready pulse never occurs without a prior grant.
- Data hold: rdata registers of the non-granted port are never modified.
- cnt is 4 bits wide; WAIT always exits at LAT, so there is no wrap.

Test Plan:
- Reset mid-WAIT: D read in flight, rst pulsed → state IDLE, no d_ready, all strobes 0. After release, an IF read at 0x4 completes normally with if_ready at cycle LAT+2.
- Single IF read: LAT=2, if_addr=0x00000010, memory returns 0x8C220004 → mem_en only in cycle 1 with mem_addr=0x10, mem_we=0; if_ready cycle 4, if_rdata=0x8C220004; stall_if=1 in cycles 0–3.
- Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_en=mem_we=1 in cycle 1 with that address/data; d_ready cycle 2; d_rdata unchanged.
- Tie after reset: if_req and d_req (load 0x40) rise together → D served first (d_ready cycle 4). IF then granted in cycle 5 with mem_en in cycle 6 and if_ready in cycle 9; stall_if=1 throughout cycles 0–8.
- Fairness: d_req held continuously for back-to-back loads with if_req also held → grants alternate D, IF, D, IF; no two consecutive D grants while if_req is pending.
- LAT=1 and LAT=15 builds: read ready at cycle 3 and cycle 17 respectively; mem_en exactly one cycle per access; busy falls in the cycle after ready.
